// File: rtl/ssd_pkg.sv
// Shared seven-segment constants: active-low {Ca..Cg} glyphs, decode modes and scan phases.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = SEG_A;

    localparam logic MODE_HEX    = 1'b0;
    localparam logic MODE_ONEHOT = 1'b1;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = SEG_0;
            4'h1: hex_glyph = SEG_1;
            4'h2: hex_glyph = SEG_2;
            4'h3: hex_glyph = SEG_3;
            4'h4: hex_glyph = SEG_4;
            4'h5: hex_glyph = SEG_5;
            4'h6: hex_glyph = SEG_6;
            4'h7: hex_glyph = SEG_7;
            4'h8: hex_glyph = SEG_8;
            4'h9: hex_glyph = SEG_9;
            4'hA: hex_glyph = SEG_A;
            4'hB: hex_glyph = SEG_B;
            4'hC: hex_glyph = SEG_C;
            4'hD: hex_glyph = SEG_D;
            4'hE: hex_glyph = SEG_E;
            default: hex_glyph = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/ssd_scan_driver_decode.sv
// Combinational glyph decode: hex on the low nibble, or one-hot bit position -> digit p+1.
module ssd_decode
    import ssd_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       mode_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_ERR;
        if (mode_i == MODE_HEX) begin
            seg_n_o = hex_glyph(data_i[3:0]);
        end else if (data_i == 8'h00) begin
            seg_n_o = SEG_0;
        end else begin
            for (int p = 0; p < 8; p++) begin
                if (data_i == (8'h01 << p)) seg_n_o = hex_glyph(4'(p + 1));
            end
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed common-anode display scanner with blanking interval and frame-aligned double buffering.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    Reset_n,
    input  logic                    load,
    input  logic [8*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   digit_mode,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   digit_dp,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    update_pending,
    output logic                    frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [NUM_DIGITS-1:0][7:0] data;
        logic [NUM_DIGITS-1:0]      mode;
        logic [NUM_DIGITS-1:0]      en;
        logic [NUM_DIGITS-1:0]      dp;
    } buf_t;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    phase_e                phase_q, phase_d;
    buf_t                  shadow_q, shadow_d, disp_q, disp_d;
    logic                  pending_q, pending_d, apply;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d, dec_seg;
    logic                  dp_q, dp_d, fdone_q, fdone_d;

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            phase_q   <= PH_BLANK;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            fdone_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fdone_q   <= fdone_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        case (phase_q)
            PH_BLANK: if (cnt_d == BLANK_END) phase_d = PH_SHOW;
            PH_SHOW:  if (cnt_d == '0)        phase_d = PH_BLANK;
            default:  phase_d = PH_BLANK;
        endcase
        // A load coinciding with the apply point lands in shadow while the old shadow is shown.
        apply     = (idx_q == '0) && (cnt_q == '0);
        shadow_d  = load ? buf_t'({digit_data, digit_mode, digit_en, digit_dp}) : shadow_q;
        disp_d    = (apply && pending_q) ? shadow_q : disp_q;
        pending_d = load | (pending_q & ~apply);
    end

    ssd_decode u_decode (
        .data_i  (disp_d.data[idx_d]),
        .mode_i  (disp_d.mode[idx_d]),
        .seg_n_o (dec_seg)
    );

    // Output registers are loaded from next state so they line up with cnt/idx in the same cycle.
    always_comb begin
        an_d    = '1;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        fdone_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
        if (phase_d == PH_SHOW && disp_d.en[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = dec_seg;
            dp_d        = ~disp_d.dp[idx_d];
        end
    end

    assign an_n           = an_q;
    assign seg_n          = seg_q;
    assign dp_n           = dp_q;
    assign frame_done     = fdone_q;
    assign update_pending = pending_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed plus random bench for ssd_scan_driver against a cycle-index arithmetic reference model.
module tb_ssd_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    logic          clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          load = 1'b0;
    logic [31:0]   digit_data = '0;
    logic [3:0]    digit_mode = '0, digit_en = '0, digit_dp = '0;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n, update_pending, frame_done;

    ssd_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .Reset_n(Reset_n), .load(load), .digit_data(digit_data),
        .digit_mode(digit_mode), .digit_en(digit_en), .digit_dp(digit_dp),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
        .update_pending(update_pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Glyph table {Ca..Cg}, active-low, written out independently of the RTL package.
    logic [6:0] GLYPH [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    int checks = 0, passes = 0, t = 0;
    bit armed = 0;
    logic [31:0] sh_data = '0, ds_data = '0;
    logic [3:0]  sh_mode = '0, sh_en = '0, sh_dp = '0;
    logic [3:0]  ds_mode = '0, ds_en = '0, ds_dp = '0;
    logic        pend = 1'b0;

    function automatic logic [6:0] ref_glyph(input logic [7:0] b, input logic m);
        if (!m)                  return GLYPH[b[3:0]];
        if (b == 8'h00)          return GLYPH[0];
        if ($countones(b) == 1)  return GLYPH[$clog2(b) + 1];
        return GLYPH[10];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    endtask

    // One clock: compare outputs for cycle t, drive inputs for edge t, advance the model.
    task automatic cyc(input logic ld, input logic [31:0] d, input logic [3:0] m,
                       input logic [3:0] e, input logic [3:0] p, input logic rn);
        int slot, c;
        logic [3:0] one, an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        @(negedge clk);
        slot = (t / SD) % ND;
        c    = t % SD;
        one  = 4'b0001;
        an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
        if (c >= BC && ds_en[slot]) begin
            an_e  = ~(one << slot);
            seg_e = ref_glyph(ds_data[slot*8 +: 8], ds_mode[slot]);
            dp_e  = ~ds_dp[slot];
        end
        if (armed) begin
            chk("an_n", 32'(an_n), 32'(an_e));
            chk("seg_n", 32'(seg_n), 32'(seg_e));
            chk("dp_n", 32'(dp_n), 32'(dp_e));
            chk("frame_done", 32'(frame_done), 32'(t % FRAME == FRAME - 1));
            chk("update_pending", 32'(update_pending), 32'(pend));
        end
        load = ld; digit_data = d; digit_mode = m; digit_en = e; digit_dp = p; Reset_n = rn;
        if (!rn) begin
            t = 0; pend = 0; armed = 1;
            sh_data = '0; sh_mode = '0; sh_en = '0; sh_dp = '0;
            ds_data = '0; ds_mode = '0; ds_en = '0; ds_dp = '0;
        end else begin
            if (t % FRAME == 0 && pend) begin
                ds_data = sh_data; ds_mode = sh_mode; ds_en = sh_en; ds_dp = sh_dp;
                pend = 0;
            end
            if (ld) begin
                sh_data = d; sh_mode = m; sh_en = e; sh_dp = p; pend = 1;
            end
            t++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, $urandom, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
    endtask

    task automatic ld(input logic [31:0] d, input logic [3:0] m, input logic [3:0] e, input logic [3:0] p);
        cyc(1'b1, d, m, e, p, 1'b1);
    endtask

    task automatic rst(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic to_cycle_mod(input int r);
        for (int i = 0; i < FRAME && (t % FRAME) != r; i++) idle(1);
    endtask

    initial begin
        // Idle after reset: nothing lit, frame_done at 31 and 63.
        rst(3);
        idle(64);
        // Load at cycle 0 (coincides with apply): shown from frame 1.
        rst(2);
        ld(32'h03020100, 4'b0000, 4'hF, 4'b0001);
        idle(80);
        // One-hot decode on digit 0.
        ld(32'h00000080, 4'b0001, 4'b0001, 4'b0000);
        idle(70);
        ld(32'h00000003, 4'b0001, 4'b0001, 4'b0000);
        idle(70);
        ld(32'h00000000, 4'b0001, 4'b0001, 4'b0001);
        idle(70);
        // Digit 2 disabled.
        ld(32'h0F0E0D0C, 4'b0000, 4'b1011, 4'b1010);
        idle(70);
        // Load Y mid-frame, then X exactly at the apply cycle.
        to_cycle_mod(10);
        ld(32'h11223344, 4'b0000, 4'hF, 4'b0101);
        to_cycle_mod(0);
        ld(32'h55667788, 4'b1111, 4'hF, 4'b1010);
        idle(70);
        // Reset during digit 2 SHOW, then nothing lit until a fresh load.
        to_cycle_mod(20);
        rst(1);
        idle(40);
        ld(32'h09080706, 4'b0000, 4'hF, 4'b1000);
        idle(70);
        // Random loads and occasional resets.
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 2)       rst(1);
            else if (r < 12) ld($urandom, 4'($urandom), 4'($urandom), 4'($urandom));
            else             idle(1);
        end
        idle(70);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
